sine_freq_meter: RTL and testbench

Receive-side companion to `sinewave`. Accepts the signed 16-bit sample stream and its per-sample strobe, detects rising zero crossings with hysteresis, and measures the period between crossings in clock cycles. It also reports the positive peak per period, plus peak-to-peak when compiled in. Used on the analysis path to check generated frequency and amplitude, e.g. 500 Hz at 10 MHz gives a 20000-cycle period.

---
 rtl/sine_meter_pkg.sv | 18 +
 rtl/sine_zero_cross.sv | 23 ++
 rtl/sine_freq_meter.sv | 131 +++++++++++++
 tb/tb_sine_freq_meter.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/sine_meter_pkg.sv
// Shared types and default constants for the sine frequency/amplitude meter.
// Shared by sine_zero_cross and sine_freq_meter.
package sine_meter_pkg;

  typedef logic signed [15:0] sample_t;

  typedef enum logic [1:0] {
    SEEK     = 2'd0,
    ARM_LOW  = 2'd1,
    RUN_HIGH = 2'd2,
    RUN_LOW  = 2'd3
  } meter_state_t;

  localparam int DEF_HYST     = 256;
  localparam int DEF_TIMEOUT  = 10_000_000;
  localparam int DEF_PERIOD_W = 32;

endpackage

// File: rtl/sine_zero_cross.sv
// Hysteresis classifier: flags a strobed sample as clearly low (<= -HYST) or
// clearly high (>= HYST); samples in the dead band raise neither flag.
module sine_zero_cross
  import sine_meter_pkg::*;
#(
  parameter int HYST = DEF_HYST
) (
  input  logic               sample_en,
  input  logic signed [15:0] sin_val,
  output logic               is_low,
  output logic               is_high
);

  localparam sample_t HYST_POS = sample_t'(HYST);
  localparam sample_t HYST_NEG = sample_t'(-HYST);

  // Signed compares so that -32768 lands in the low band.
  always_comb begin
    is_low  = sample_en && (sin_val <= HYST_NEG);
    is_high = sample_en && (sin_val >= HYST_POS);
  end

endmodule

// File: rtl/sine_freq_meter.sv
// Measures period (clk cycles between rising crossings) and positive peak of a
// strobed sine stream. Define SINE_METER_PP_EN to also report peak-to-peak.
module sine_freq_meter
  import sine_meter_pkg::*;
#(
  parameter int HYST     = DEF_HYST,
  parameter int TIMEOUT  = DEF_TIMEOUT,
  parameter int PERIOD_W = DEF_PERIOD_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sample_en,
  input  logic signed [15:0]  sin_val,
  output logic [PERIOD_W-1:0] period,
  output logic signed [15:0]  peak,
  output logic [16:0]         pk2pk,
  output logic                meas_valid,
  output logic                no_signal
);

  localparam logic [PERIOD_W-1:0] CNT_MAX = '1;
  localparam logic [PERIOD_W-1:0] TO_LAST = PERIOD_W'(TIMEOUT - 1);

  meter_state_t        state;
  logic [PERIOD_W-1:0] cnt;
  logic [PERIOD_W-1:0] cnt_inc;
  sample_t             runmax;
  sample_t             hi_ext;
  logic                is_low;
  logic                is_high;
  logic                in_run;
  logic                crossing;
  logic                timeout;

  sine_zero_cross #(
    .HYST (HYST)
  ) u_zero_cross (
    .sample_en (sample_en),
    .sin_val   (sin_val),
    .is_low    (is_low),
    .is_high   (is_high)
  );

  // A crossing in the timeout cycle still counts; timeout only fires without one.
  always_comb begin
    in_run   = (state == RUN_HIGH) || (state == RUN_LOW);
    crossing = (state == RUN_LOW) && is_high;
    timeout  = in_run && (cnt == TO_LAST) && !crossing;
    cnt_inc  = (cnt == CNT_MAX) ? cnt : cnt + PERIOD_W'(1);
    hi_ext   = (sin_val > runmax) ? sin_val : runmax;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= SEEK;
      cnt        <= '0;
      runmax     <= '0;
      period     <= '0;
      peak       <= '0;
      meas_valid <= 1'b0;
      no_signal  <= 1'b1;
    end else begin
      meas_valid <= 1'b0;
      case (state)
        SEEK: begin
          cnt <= '0;
          if (is_low) state <= ARM_LOW;
        end
        ARM_LOW: begin
          cnt <= '0;
          if (is_high) begin
            state  <= RUN_HIGH;
            runmax <= sin_val;
          end
        end
        RUN_HIGH, RUN_LOW: begin
          if (crossing) begin
            state      <= RUN_HIGH;
            period     <= cnt_inc;
            peak       <= hi_ext;
            meas_valid <= 1'b1;
            no_signal  <= 1'b0;
            cnt        <= '0;
            runmax     <= sin_val;
          end else if (timeout) begin
            state     <= SEEK;
            no_signal <= 1'b1;
            cnt       <= '0;
          end else begin
            cnt <= cnt_inc;
            if (sample_en) runmax <= hi_ext;
            if ((state == RUN_HIGH) && is_low) state <= RUN_LOW;
          end
        end
        default: begin
          state <= SEEK;
          cnt   <= '0;
        end
      endcase
    end
  end

`ifdef SINE_METER_PP_EN
  sample_t runmin;
  sample_t lo_ext;

  always_comb begin
    lo_ext = (sin_val < runmin) ? sin_val : runmin;
  end

  // Extremes include the closing crossing sample; the difference is never negative.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      runmin <= '0;
      pk2pk  <= '0;
    end else begin
      if ((state == ARM_LOW) && is_high) begin
        runmin <= sin_val;
      end else if (crossing) begin
        pk2pk  <= {hi_ext[15], hi_ext} - {lo_ext[15], lo_ext};
        runmin <= sin_val;
      end else if (in_run && !timeout && sample_en) begin
        runmin <= lo_ext;
      end
    end
  end
`else
  assign pk2pk = '0;
`endif

endmodule

// File: tb/tb_sine_freq_meter.sv
// Scoreboard bench for sine_freq_meter (HYST=256, TIMEOUT=1000): directed sample
// sequences push expected measurements; a negedge monitor checks each meas_valid.
module tb_sine_freq_meter;
  import sine_meter_pkg::*;

  typedef struct {
    logic [31:0] period;
    logic [15:0] peak;
    logic [16:0] pk2pk;
  } meas_t;

  logic               clk;
  logic               reset;
  logic               sample_en;
  logic signed [15:0] sin_val;
  logic [31:0]        period;
  logic signed [15:0] peak;
  logic [16:0]        pk2pk;
  logic               meas_valid;
  logic               no_signal;

  meas_t exp_q[$];
  int    n_checks = 0;
  int    n_pass   = 0;
  int    n_pushed = 0;
  int    n_seen   = 0;

  sine_freq_meter #(
    .HYST     (256),
    .TIMEOUT  (1000),
    .PERIOD_W (32)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .sample_en  (sample_en),
    .sin_val    (sin_val),
    .period     (period),
    .peak       (peak),
    .pk2pk      (pk2pk),
    .meas_valid (meas_valid),
    .no_signal  (no_signal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  // Present one sample for one rising edge; returns 1 time unit after the edge.
  task automatic applyStimulus(input int value, input logic en, input int reps);
    for (int i = 0; i < reps; i++) begin
      sin_val   = 16'(value);
      sample_en = en;
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [16:0] pp_exp(input int v);
`ifdef SINE_METER_PP_EN
    return 17'(v);
`else
    return 17'(v * 0);
`endif
  endfunction

  task automatic expectMeas(input int per, input int pk, input int pp);
    meas_t m;
    m.period = 32'(per);
    m.peak   = 16'(pk);
    m.pk2pk  = pp_exp(pp);
    exp_q.push_back(m);
    n_pushed++;
  endtask

  // Monitor: every meas_valid pulse must match the oldest expected measurement.
  always @(negedge clk) begin
    if (meas_valid) begin
      meas_t m;
      n_seen++;
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_meas_valid", 32'd1, 32'd0);
      end else begin
        m = exp_q.pop_front();
        checkOutput("period", period, m.period);
        checkOutput("peak", 32'(peak), 32'(m.peak));
        checkOutput("pk2pk", 32'(pk2pk), 32'(m.pk2pk));
      end
    end
  end

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_period"}, period, 32'd0);
    checkOutput({tag, "_peak"}, 32'(peak), 32'd0);
    checkOutput({tag, "_pk2pk"}, 32'(pk2pk), 32'd0);
    checkOutput({tag, "_meas_valid"}, 32'(meas_valid), 32'd0);
    checkOutput({tag, "_no_signal"}, 32'(no_signal), 32'd1);
  endtask

  initial begin
    reset     = 1'b1;
    sample_en = 1'b0;
    sin_val   = '0;
    #3;
    checkResetValues("por");
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Square wave: reference at first +1000, counted crossing 100 edges later.
    applyStimulus(-1000, 1'b1, 10);
    applyStimulus(1000, 1'b1, 10);
    applyStimulus(-1000, 1'b1, 90);
    expectMeas(100, 1000, 2000);
    applyStimulus(1000, 1'b1, 1);
    checkOutput("no_signal_after_first", 32'(no_signal), 32'd0);

    // Larger peak inside the period.
    applyStimulus(2000, 1'b1, 3);
    applyStimulus(-500, 1'b1, 6);
    expectMeas(10, 2000, 2500);
    applyStimulus(400, 1'b1, 1);

    // Threshold boundaries: 255 and -255 ignored, -256 low, 256 high.
    applyStimulus(255, 1'b1, 2);
    applyStimulus(-256, 1'b1, 1);
    applyStimulus(-255, 1'b1, 3);
    expectMeas(7, 400, 656);
    applyStimulus(256, 1'b1, 1);

    // Most negative sample, then unstrobed cycles that count but are not seen.
    applyStimulus(-32768, 1'b1, 1);
    applyStimulus(30000, 1'b0, 5);
    expectMeas(7, 1000, 33768);
    applyStimulus(1000, 1'b1, 1);

    // Crossing lands exactly on the timeout cycle: measurement wins.
    applyStimulus(-1000, 1'b1, 999);
    expectMeas(1000, 1000, 2000);
    applyStimulus(1000, 1'b1, 1);
    checkOutput("no_signal_at_boundary", 32'(no_signal), 32'd0);

    // No further crossing: no_signal rises exactly 1000 edges after the reference.
    applyStimulus(1000, 1'b1, 999);
    checkOutput("no_signal_before_timeout", 32'(no_signal), 32'd0);
    applyStimulus(1000, 1'b1, 1);
    checkOutput("no_signal_at_timeout", 32'(no_signal), 32'd1);
    checkOutput("period_held_after_timeout", period, 32'd1000);

    // Back in SEEK: needs low, high (reference), low, high again.
    applyStimulus(1000, 1'b1, 5);
    applyStimulus(-1000, 1'b1, 3);
    applyStimulus(1000, 1'b1, 5);
    applyStimulus(-1000, 1'b1, 5);
    checkOutput("no_signal_before_remeasure", 32'(no_signal), 32'd1);
    expectMeas(10, 1000, 2000);
    applyStimulus(1000, 1'b1, 1);
    checkOutput("no_signal_after_remeasure", 32'(no_signal), 32'd0);

    // Reset mid-period clears outputs immediately.
    applyStimulus(-1000, 1'b1, 3);
    reset = 1'b1;
    #1;
    checkResetValues("midrun");
    @(posedge clk);
    #1;
    reset = 1'b0;

    // A high right after reset is not a measurement; sub-threshold noise is ignored.
    applyStimulus(1000, 1'b1, 2);
    for (int i = 0; i < 2500; i++) begin
      applyStimulus(200, 1'b1, 1);
      applyStimulus(-200, 1'b1, 1);
    end
    checkOutput("no_signal_after_noise", 32'(no_signal), 32'd1);
    checkOutput("period_after_noise", period, 32'd0);

    applyStimulus(-1000, 1'b1, 3);
    applyStimulus(1000, 1'b1, 5);
    applyStimulus(-1000, 1'b1, 4);
    expectMeas(9, 1000, 2000);
    applyStimulus(1000, 1'b1, 1);
    applyStimulus(0, 1'b1, 3);

    checkOutput("pending_expectations", 32'(exp_q.size()), 32'd0);
    checkOutput("meas_count", 32'(n_seen), 32'(n_pushed));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
